// File: rtl/laundry_pkg.sv
// Shared types and constants for the laundry water-inlet arbiter.
//   state_e  : arbiter FSM encoding (IDLE / GRANT / SETTLE)
//   *_DEF    : default parameter values for the top level
//   onehot() : index to one-hot vector, MAX_MACHINES wide
package laundry_pkg;

  localparam int unsigned MAX_MACHINES     = 8;
  localparam int unsigned IDX_W            = 3;
  localparam int unsigned NUM_MACHINES_DEF = 4;
  localparam int unsigned MAX_FILL_DEF     = 64;
  localparam int unsigned SETTLE_DEF       = 2;
  localparam int unsigned CNT_W_DEF        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // One-hot of a machine index; callers cast down to their machine count.
  function automatic logic [MAX_MACHINES-1:0] onehot(input logic [IDX_W-1:0] idx);
    return MAX_MACHINES'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   eligible : per-requester eligibility
//   ptr      : first index to consider (searches upward, wraps to 0)
//   winner   : chosen index (0 when nothing is eligible)
//   valid    : at least one requester is eligible
module rr_pick
  import laundry_pkg::*;
#(
  parameter int unsigned N = NUM_MACHINES_DEF
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_any;

  // Descending scan: the last hit is the lowest index overall (lo) and the
  // lowest index at or above ptr (hi); hi wins, lo covers the wrap-around.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = IDX_W'(i);
        if (i >= int'(ptr)) begin
          hi_idx = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
    winner = hi_any ? hi_idx : lo_idx;
    valid  = |eligible;
  end

endmodule

// File: rtl/laundry_water_arbiter.sv
// Shares one mains water inlet among NUM_MACHINES washer controllers.
// Round-robin grant, forced valve-settle gap after every release, and a
// fill-time budget that revokes the grant and latches a sticky fault.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   fill_req    : per-machine fill valve request
//   filled      : per-machine water-level-reached sensor
//   fault_clr   : per-machine pulse clearing the sticky fault
//   fill_grant  : one-hot-or-zero inlet valve enable
//   inlet_busy  : high while in GRANT or SETTLE
//   fault       : sticky timeout flags
//   grant_id    : index of the current or last granted machine
module laundry_water_arbiter
  import laundry_pkg::*;
#(
  parameter int unsigned NUM_MACHINES    = NUM_MACHINES_DEF,
  parameter int unsigned MAX_FILL_CYCLES = MAX_FILL_DEF,
  parameter int unsigned SETTLE_CYCLES   = SETTLE_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_MACHINES-1:0] fill_req,
  input  logic [NUM_MACHINES-1:0] filled,
  input  logic [NUM_MACHINES-1:0] fault_clr,
  output logic [NUM_MACHINES-1:0] fill_grant,
  output logic                    inlet_busy,
  output logic [NUM_MACHINES-1:0] fault,
  output logic [IDX_W-1:0]        grant_id
);

  state_e                  state_q, state_d;
  logic [NUM_MACHINES-1:0] grant_q, grant_d;
  logic [NUM_MACHINES-1:0] fault_q, fault_d;
  logic [NUM_MACHINES-1:0] fault_set;
  logic [IDX_W-1:0]        grant_id_q, grant_id_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;

  logic [NUM_MACHINES-1:0] eligible;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic                    win_filled;
  logic                    win_req;
  logic                    timeout;

  assign eligible = fill_req & ~fault_q & ~filled;

  // Winner status via the grant mask avoids indexing by grant_id.
  assign win_filled = |(filled & grant_q);
  assign win_req    = |(fill_req & grant_q);
  assign timeout    = (cnt_q == CNT_W'(MAX_FILL_CYCLES - 1));

  rr_pick #(
    .N (NUM_MACHINES)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    fault_set  = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          grant_d    = NUM_MACHINES'(onehot(pick_idx));
          grant_id_d = pick_idx;
          cnt_d      = '0;
          ptr_d      = (pick_idx == IDX_W'(NUM_MACHINES - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion beats withdraw beats timeout; only a timeout faults.
        if (win_filled || !win_req || timeout) begin
          state_d = SETTLE;
          grant_d = '0;
          cnt_d   = '0;
          if (!win_filled && win_req) begin
            fault_set = grant_q;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Set takes priority over a same-cycle clear.
    fault_d = (fault_q & ~fault_clr) | fault_set;
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      fault_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      fault_q    <= fault_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign fill_grant = grant_q;
  assign inlet_busy = busy_q;
  assign fault      = fault_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_laundry_water_arbiter.sv
// Directed bench for laundry_water_arbiter: expected grants (vector and
// cycle) are queued as stimulus is applied and popped when a new grant
// appears; other outputs are checked at fixed cycles.
module tb_laundry_water_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fill_req = '0;
  logic [3:0] filled = '0;
  logic [3:0] fault_clr = '0;
  logic [3:0] fill_grant;
  logic       inlet_busy;
  logic [3:0] fault;
  logic [2:0] grant_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] g;
    int         c;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] prev_grant = '0;

  laundry_water_arbiter #(
    .NUM_MACHINES    (4),
    .MAX_FILL_CYCLES (64),
    .SETTLE_CYCLES   (2),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fill_req   (fill_req),
    .filled     (filled),
    .fault_clr  (fault_clr),
    .fill_grant (fill_grant),
    .inlet_busy (inlet_busy),
    .fault      (fault),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic expect_grant(input logic [3:0] g, input int c);
    exp_t e;
    e.g = g;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    fill_req  = '0;
    filled    = '0;
    fault_clr = '0;
    reset     = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Grant monitor on the falling edge: at-most-one-hot every cycle, and
  // each new grant must match the head of the scoreboard.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("onehot0", 32'($countones(fill_grant) <= 1), 32'd1);
      if (fill_grant != '0 && fill_grant != prev_grant) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", 32'(fill_grant), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("grant_vec", 32'(fill_grant), 32'(mon_e.g));
          chk("grant_cyc", cyc, mon_e.c);
        end
      end
      prev_grant = fill_grant;
    end
  end

  initial begin
    int t0;
    int g;

    // Reset state
    step();
    step();
    reset = 1'b1;
    chk("rst_grant", 32'(fill_grant), 32'd0);
    chk("rst_busy", 32'(inlet_busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);

    // 1: single requester, normal completion
    run_to(5);
    fill_req = 4'b0001;
    expect_grant(4'b0001, 6);
    run_to(6);
    chk("t1_grant", 32'(fill_grant), 32'h1);
    chk("t1_busy", 32'(inlet_busy), 32'd1);
    run_to(20);
    filled = 4'b0001;
    run_to(21);
    chk("t1_release", 32'(fill_grant), 32'd0);
    chk("t1_settle_busy_a", 32'(inlet_busy), 32'd1);
    run_to(22);
    chk("t1_settle_busy_b", 32'(inlet_busy), 32'd1);
    run_to(23);
    chk("t1_idle_busy", 32'(inlet_busy), 32'd0);
    chk("t1_fault", 32'(fault), 32'd0);

    // 2: round robin with all four requesting
    do_reset();
    t0 = cyc;
    fill_req = 4'b1111;
    for (int k = 0; k < 5; k++) expect_grant(4'b0001 << (k % 4), t0 + 1 + 9 * k);
    for (int k = 0; k < 5; k++) begin
      g = t0 + 1 + 9 * k;
      run_to(g);
      chk("t2_id", 32'(grant_id), k % 4);
      run_to(g + 5);
      filled = 4'b0001 << (k % 4);
      if (k == 4) fill_req = '0;
      step();
      filled = '0;
      chk("t2_drop", 32'(fill_grant), 32'd0);
      run_to(g + 8);
      chk("t2_gap", 32'(fill_grant), 32'd0);
    end

    // 3: timeout, fault set wins over same-cycle clear, re-grant after clear
    do_reset();
    t0 = cyc;
    fill_req = 4'b0100;
    expect_grant(4'b0100, t0 + 1);
    run_to(t0 + 64);
    chk("t3_held_last", 32'(fill_grant), 32'h4);
    fault_clr = 4'b0100;
    step();
    fault_clr = '0;
    chk("t3_timeout_drop", 32'(fill_grant), 32'd0);
    chk("t3_fault_set_wins", 32'(fault), 32'h4);
    chk("t3_settle_busy", 32'(inlet_busy), 32'd1);
    run_to(t0 + 75);
    chk("t3_blocked", 32'(fill_grant), 32'd0);
    chk("t3_idle_busy", 32'(inlet_busy), 32'd0);
    chk("t3_fault_sticky", 32'(fault), 32'h4);
    fault_clr = 4'b0100;
    step();
    fault_clr = '0;
    chk("t3_fault_cleared", 32'(fault), 32'd0);
    expect_grant(4'b0100, t0 + 77);
    run_to(t0 + 77);
    chk("t3_regrant", 32'(fill_grant), 32'h4);
    filled = 4'b0100;
    fill_req = '0;
    step();
    filled = '0;

    // 4: withdraw, then pending machine 3 after the settle gap
    do_reset();
    t0 = cyc;
    fill_req = 4'b0010;
    expect_grant(4'b0010, t0 + 1);
    run_to(t0 + 2);
    fill_req = 4'b1010;
    run_to(t0 + 10);
    fill_req = 4'b1000;
    expect_grant(4'b1000, t0 + 14);
    run_to(t0 + 11);
    chk("t4_drop", 32'(fill_grant), 32'd0);
    chk("t4_busy", 32'(inlet_busy), 32'd1);
    chk("t4_nofault", 32'(fault), 32'd0);
    run_to(t0 + 13);
    chk("t4_gap", 32'(fill_grant), 32'd0);
    run_to(t0 + 14);
    chk("t4_grant3", 32'(fill_grant), 32'h8);
    chk("t4_id3", 32'(grant_id), 32'd3);
    filled = 4'b1000;
    fill_req = '0;
    step();
    filled = '0;

    // 5: reset mid-grant, first grant afterwards goes to machine 0
    do_reset();
    t0 = cyc;
    fill_req = 4'b0100;
    expect_grant(4'b0100, t0 + 1);
    run_to(t0 + 4);
    chk("t5_pre", 32'(fill_grant), 32'h4);
    reset = 1'b0;
    fill_req = 4'b1111;
    step();
    reset = 1'b1;
    chk("t5_rst_grant", 32'(fill_grant), 32'd0);
    chk("t5_rst_busy", 32'(inlet_busy), 32'd0);
    chk("t5_rst_id", 32'(grant_id), 32'd0);
    expect_grant(4'b0001, t0 + 6);
    run_to(t0 + 6);
    chk("t5_first", 32'(fill_grant), 32'h1);
    filled = 4'b0001;
    fill_req = '0;
    step();
    filled = '0;

    // 6: completion coinciding with the timeout cycle does not fault
    do_reset();
    t0 = cyc;
    fill_req = 4'b0001;
    g = t0 + 1;
    expect_grant(4'b0001, g);
    run_to(g + 63);
    chk("t6_held", 32'(fill_grant), 32'h1);
    filled = 4'b0001;
    step();
    filled = '0;
    fill_req = '0;
    chk("t6_drop", 32'(fill_grant), 32'd0);
    chk("t6_nofault", 32'(fault), 32'd0);
    run_to(g + 70);
    chk("t6_idle", 32'(inlet_busy), 32'd0);
    chk("t6_fault_final", 32'(fault), 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
